// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for the pipelined logic unit: the operand/op request side
// and the result side, each carried with its own valid/ready pair.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_parity;

    // Environment side: issues transactions and consumes results.
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_parity
    );

    // Logic unit side.
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit. S1 captures operands and op. S2
// evaluates one of eight bitwise ops and registers the result, zero flag and
// parity flag. A stalled S2 back-pressures S1, and a full S1 lowers in_ready.
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_unit_pipe_if.slave    bus
);

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_NOT_A = 3'd7
    } op_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    op_e              r_s1_op;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_parity;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_result;

    // S2 takes S1's transaction whenever S2 is empty or is emptying this edge.
    assign w_s2_load  = r_s1_valid && (!r_out_valid || bus.out_ready);
    // S1 can accept when empty or when its contents move on this edge.
    // in_valid is deliberately absent so there is no valid-to-ready loop.
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = bus.in_valid && w_in_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_y      = r_out_y;
    assign bus.out_zero   = r_out_zero;
    assign bus.out_parity = r_out_parity;

    // S1 occupancy: refilled (or emptied) whenever S1 is free to change.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values of the others, independent of order.
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
        end
    end

    // S1 payload capture on an accepted input transaction.
    always_ff @(posedge clk) begin
        // NOTE: payload flops carry no reset; the valid bit alone qualifies
        // them, so their contents after reset are never observed.
        if (w_in_xfer) begin
            r_s1_a  <= bus.in_a;
            r_s1_b  <= bus.in_b;
            r_s1_op <= op_e'(bus.in_op);
        end
    end

    // Bitwise operation on the S1 contents.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // w_result unassigned and infers a latch.
        w_result = '0;
        case (r_s1_op)
            OP_AND:   w_result = r_s1_a & r_s1_b;
            OP_OR:    w_result = r_s1_a | r_s1_b;
            OP_XOR:   w_result = r_s1_a ^ r_s1_b;
            OP_NAND:  w_result = ~(r_s1_a & r_s1_b);
            OP_NOR:   w_result = ~(r_s1_a | r_s1_b);
            OP_XNOR:  w_result = ~(r_s1_a ^ r_s1_b);
            OP_ANDN:  w_result = r_s1_a & ~r_s1_b;
            OP_NOT_A: w_result = ~r_s1_a;
            default:  w_result = '0;
        endcase
    end

    // S2 result register and flags: change only on s2_load, hold during stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_y      <= '0;
            r_out_zero   <= 1'b1;
            r_out_parity <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_out_valid  <= 1'b1;
                r_out_y      <= w_result;
                r_out_zero   <= (w_result == '0);
                r_out_parity <= ^w_result;
            end else if (bus.out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios on a 16-bit instance and
// randomised scoreboard runs on 32-bit and 1-bit instances.
module tb_logic_unit_pipe;

    int checks = 0;
    int errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(16), .OPW(3)) if16 ();
    logic_unit_pipe_if #(.WIDTH(32), .OPW(3)) if32 ();
    logic_unit_pipe_if #(.WIDTH(1),  .OPW(3)) if1  ();

    logic_unit_pipe #(.WIDTH(16), .OPW(3)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    logic_unit_pipe #(.WIDTH(32), .OPW(3)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    logic_unit_pipe #(.WIDTH(1),  .OPW(3)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Reference: the op table applied to zero-extended operands, cut to width.
    function automatic logic [63:0] ref_op(int op, logic [63:0] a, logic [63:0] b, int w);
        logic [63:0] y;
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (op)
            0:       y = a & b;
            1:       y = a | b;
            2:       y = a ^ b;
            3:       y = ~(a & b);
            4:       y = ~(a | b);
            5:       y = ~(a ^ b);
            6:       y = a & ~b;
            default: y = ~a;
        endcase
        return y & mask;
    endfunction

    task automatic drive16(logic v, logic [15:0] a, logic [15:0] b, logic [2:0] op);
        if16.in_valid = v;
        if16.in_a     = a;
        if16.in_b     = b;
        if16.in_op    = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive16(1'b1, 16'hFFFF, 16'h1234, 3'd1);
        if16.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", if16.out_valid); end
        checks++;
        if (if16.out_y !== 16'h0000) begin errors++; $display("FAIL reset_out_y got %h exp 0000", if16.out_y); end
        checks++;
        if (if16.out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %b exp 1", if16.out_zero); end
        checks++;
        if (if16.out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity got %b exp 0", if16.out_parity); end
        checks++;
        if (if16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", if16.in_ready); end
        drive16(1'b0, 16'h0, 16'h0, 3'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset cycle %0d out_valid got %b exp 0", c, if16.out_valid); end
        end
    endtask

    task automatic test_op_sweep();
        logic [15:0] exp_y [8] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
                                   16'h000F, 16'hF00F, 16'h00F0, 16'h0F0F};
        if16.out_ready = 1'b1;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            if (j < 8) drive16(1'b1, 16'hF0F0, 16'hFF00, 3'(j));
            else       drive16(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            if (j >= 2 && j < 10) begin
                checks++;
                if (if16.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid op %0d got %b exp 1", j - 2, if16.out_valid); end
                checks++;
                if (if16.out_y !== exp_y[j-2]) begin errors++; $display("FAIL sweep_y op %0d got %h exp %h", j - 2, if16.out_y, exp_y[j-2]); end
                checks++;
                if (if16.out_parity !== 1'b0) begin errors++; $display("FAIL sweep_parity op %0d got %b exp 0", j - 2, if16.out_parity); end
                checks++;
                if (if16.out_zero !== 1'b0) begin errors++; $display("FAIL sweep_zero op %0d got %b exp 0", j - 2, if16.out_zero); end
            end
            if (j == 10) begin
                checks++;
                if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain out_valid got %b exp 0", if16.out_valid); end
            end
        end
    endtask

    task automatic test_zero_flag();
        if16.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0)      drive16(1'b1, 16'h5555, 16'hAAAA, 3'd0);
            else if (j == 1) drive16(1'b1, 16'h0001, 16'h0000, 3'd2);
            else             drive16(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            if (j == 2) begin
                checks++;
                if (if16.out_valid !== 1'b1 || if16.out_y !== 16'h0000 || if16.out_zero !== 1'b1 || if16.out_parity !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_and got v=%b y=%h z=%b p=%b exp v=1 y=0000 z=1 p=0", if16.out_valid, if16.out_y, if16.out_zero, if16.out_parity);
                end
            end
            if (j == 3) begin
                checks++;
                if (if16.out_valid !== 1'b1 || if16.out_y !== 16'h0001 || if16.out_zero !== 1'b0 || if16.out_parity !== 1'b1) begin
                    errors++;
                    $display("FAIL zero_xor got v=%b y=%h z=%b p=%b exp v=1 y=0001 z=0 p=1", if16.out_valid, if16.out_y, if16.out_zero, if16.out_parity);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_q [$];
        logic [15:0] first_y = '0;
        logic [15:0] cur_a = 16'($urandom);
        logic [15:0] cur_b = 16'($urandom);
        logic [2:0]  cur_op = 3'($urandom);
        logic [15:0] want;
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 25 && !(sent == 4 && got == 4); c++) begin
            @(negedge clk);
            if16.out_ready = (c >= 5);
            if (sent < 4) drive16(1'b1, cur_a, cur_b, cur_op);
            else          drive16(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            if (c < 5) begin
                checks++;
                if (if16.in_ready !== (c < 2)) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp %b", c, if16.in_ready, (c < 2)); end
            end
            if (c >= 2 && c < 5) begin
                checks++;
                if (if16.out_valid !== 1'b1 || if16.out_y !== first_y) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d got v=%b y=%h exp v=1 y=%h", c, if16.out_valid, if16.out_y, first_y);
                end
            end
            if (if16.out_valid === 1'b1 && if16.out_ready === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_output got %h exp none", if16.out_y);
                end else begin
                    want = exp_q.pop_front();
                    if (if16.out_y !== want) begin errors++; $display("FAIL bp_order result %0d got %h exp %h", got, if16.out_y, want); end
                end
            end
            if (if16.in_valid === 1'b1 && if16.in_ready === 1'b1) begin
                want = 16'(ref_op(int'(cur_op), 64'(cur_a), 64'(cur_b), 16));
                if (sent == 0) first_y = want;
                exp_q.push_back(want);
                sent++;
                cur_a  = 16'($urandom);
                cur_b  = 16'($urandom);
                cur_op = 3'($urandom);
            end
        end
        checks++;
        if (got != 4 || sent != 4) begin errors++; $display("FAIL bp_count got sent=%0d drained=%0d exp 4 and 4", sent, got); end
        @(negedge clk);
        drive16(1'b0, 16'h0, 16'h0, 3'd0);
        #1;
        checks++;
        if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate out_valid got %b exp 0", if16.out_valid); end
    endtask

    task automatic test_reset_mid();
        if16.out_ready = 1'b1;
        @(negedge clk);
        drive16(1'b1, 16'h1234, 16'h00FF, 3'd1);
        @(negedge clk);
        drive16(1'b1, 16'hABCD, 16'hFFFF, 3'd0);
        @(posedge clk);
        drive16(1'b0, 16'h0, 16'h0, 3'd0);
        #2;
        checks++;
        if (if16.out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight out_valid got %b exp 1", if16.out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1 || if16.out_y !== 16'h0 || if16.out_zero !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b rdy=%b y=%h z=%b exp v=0 rdy=1 y=0000 z=1", if16.out_valid, if16.in_ready, if16.out_y, if16.out_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost cycle %0d out_valid got %b exp 0", c, if16.out_valid); end
        end
    endtask

    task automatic test_random_w32(int cycles);
        logic [31:0] exp_q [$];
        logic [31:0] want;
        logic        r0;
        logic        r1;
        for (int c = 0; c < cycles + 12; c++) begin
            @(negedge clk);
            if (c < cycles) begin
                if32.in_valid  = ($urandom_range(0, 3) != 0);
                if32.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                if32.in_valid  = 1'b0;
                if32.out_ready = 1'b1;
            end
            if32.in_a  = 32'($urandom);
            if32.in_b  = 32'($urandom);
            if32.in_op = 3'($urandom);
            #1;
            r0 = if32.in_ready;
            if32.in_valid = ~if32.in_valid;
            #1;
            r1 = if32.in_ready;
            if32.in_valid = ~if32.in_valid;
            #1;
            checks++;
            if (r0 !== r1) begin errors++; $display("FAIL w32_ready_indep cycle %0d got %b exp %b", c, r1, r0); end
            if (if32.out_valid === 1'b1 && if32.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL w32_extra cycle %0d got %h exp none", c, if32.out_y);
                end else begin
                    want = exp_q.pop_front();
                    if (if32.out_y !== want || if32.out_zero !== (want == 32'd0) || if32.out_parity !== ^want) begin
                        errors++;
                        $display("FAIL w32_result cycle %0d got y=%h z=%b p=%b exp y=%h z=%b p=%b", c, if32.out_y, if32.out_zero, if32.out_parity, want, (want == 32'd0), ^want);
                    end
                end
            end
            if (if32.in_valid === 1'b1 && if32.in_ready === 1'b1)
                exp_q.push_back(32'(ref_op(int'(if32.in_op), 64'(if32.in_a), 64'(if32.in_b), 32)));
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL w32_lost got %0d pending exp 0", exp_q.size()); end
    endtask

    task automatic test_random_w1(int cycles);
        logic exp_q [$];
        logic want;
        logic r0;
        logic r1;
        for (int c = 0; c < cycles + 12; c++) begin
            @(negedge clk);
            if (c < cycles) begin
                if1.in_valid  = ($urandom_range(0, 3) != 0);
                if1.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                if1.in_valid  = 1'b0;
                if1.out_ready = 1'b1;
            end
            if1.in_a  = 1'($urandom);
            if1.in_b  = 1'($urandom);
            if1.in_op = 3'($urandom);
            #1;
            r0 = if1.in_ready;
            if1.in_valid = ~if1.in_valid;
            #1;
            r1 = if1.in_ready;
            if1.in_valid = ~if1.in_valid;
            #1;
            checks++;
            if (r0 !== r1) begin errors++; $display("FAIL w1_ready_indep cycle %0d got %b exp %b", c, r1, r0); end
            if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL w1_extra cycle %0d got %b exp none", c, if1.out_y);
                end else begin
                    want = exp_q.pop_front();
                    if (if1.out_y !== want || if1.out_zero !== ~want || if1.out_parity !== want) begin
                        errors++;
                        $display("FAIL w1_result cycle %0d got y=%b z=%b p=%b exp y=%b z=%b p=%b", c, if1.out_y, if1.out_zero, if1.out_parity, want, ~want, want);
                    end
                end
            end
            if (if1.in_valid === 1'b1 && if1.in_ready === 1'b1)
                exp_q.push_back(1'(ref_op(int'(if1.in_op), 64'(if1.in_a), 64'(if1.in_b), 1)));
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL w1_lost got %0d pending exp 0", exp_q.size()); end
    endtask

    initial begin
        drive16(1'b0, 16'h0, 16'h0, 3'd0);
        if16.out_ready = 1'b0;
        if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_op = '0; if32.out_ready = 1'b0;
        if1.in_valid  = 1'b0; if1.in_a  = '0; if1.in_b  = '0; if1.in_op  = '0; if1.out_ready  = 1'b0;

        test_reset();
        test_op_sweep();
        test_zero_flag();
        test_backpressure();
        test_reset_mid();
        fork
            test_random_w32(10000);
            test_random_w1(10000);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
